dmem_responder: RTL and testbench

- Data-memory responder: the memory-side end of the load/store interface driven by alu_mem (`mem_addr_o`, `mem_data_o`, write enable).
- Accepts one word request at a time over a valid/ready handshake.
- Holds the request for a programmable number of wait states, then commits the store or performs the load.
- Returns a response over a second valid/ready handshake; sits between alu_mem and the processor's data storage.

---
 rtl/simple_processor_pkg.sv | 16 +
 rtl/dmem_array.sv | 25 ++
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_processor_pkg.sv
// Shared types and constants for the simple processor and its data-memory
// responder. DATA_WIDTH is the machine word and address width.
package simple_processor_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int DMEM_DEPTH   = 256;
  localparam int DMEM_LATENCY = 2;

  // Request sequencing of the data-memory responder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, combinational read, shared
// index. Contents are never reset.
module dmem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                     clk_i,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Commit a store to the selected word on the rising edge.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the load/store interface. Accepts one word request,
// waits LATENCY cycles, performs the access, then holds a registered
// response until the requester takes it.
module dmem_responder
  import simple_processor_pkg::*;
#(
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int DEPTH      = DMEM_DEPTH,
  parameter int LATENCY    = DMEM_LATENCY
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic                  cap_we_q;
  logic [DATA_WIDTH-1:0] cap_addr_q;
  logic [DATA_WIDTH-1:0] cap_wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  accept;
  logic                  do_access;
  logic                  acc_we;
  logic [DATA_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_err;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign accept = (state_q == IDLE) && req_valid_i;

  // Pick the access source: live inputs when a zero-latency access happens
  // at acceptance, otherwise the captured request; decide if this is the
  // access edge and whether the address is legal.
  always_comb begin
    acc_we    = cap_we_q;
    acc_addr  = cap_addr_q;
    acc_wdata = cap_wdata_q;
    do_access = 1'b0;
    if (LATENCY == 0) begin
      acc_we    = req_we_i;
      acc_addr  = req_addr_i;
      acc_wdata = req_wdata_i;
      do_access = accept;
    end else begin
      do_access = (state_q == WAIT) && (cnt_q == '0);
    end
    acc_err = (acc_addr[1:0] != 2'b00) || (|acc_addr[DATA_WIDTH-1:AW+2]);
    mem_we  = do_access && acc_we && !acc_err;
  end

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk_i (clk_i),
    .we    (mem_we),
    .idx   (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  // State register.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, count out wait states, release on the
  // response handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)      state_d = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs follow directly from the registered state.
  always_comb begin
    req_ready_o = (state_q == IDLE);
    rsp_valid_o = (state_q == RESP);
  end

  // Capture the request and load the wait-state counter on acceptance.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt_q       <= '0;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
    end else if (accept) begin
      cnt_q       <= CW'((LATENCY > 0) ? (LATENCY - 1) : 0);
      cap_we_q    <= req_we_i;
      cap_addr_q  <= req_addr_i;
      cap_wdata_q <= req_wdata_i;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Response registers: loaded at the access edge, cleared on handshake so
  // they read zero whenever no response is presented.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (do_access) begin
      rdata_q <= (acc_we || acc_err) ? '0 : mem_rdata;
      err_q   <= acc_err;
    end else if ((state_q == RESP) && rsp_ready_i) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomised checks of dmem_responder with default parameters
// (32-bit words, 256 words, 2 wait states).
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [16];

  dmem_responder dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Present a request at a falling edge and wait for it to be accepted.
  // Returns at the falling edge after the accepting rising edge.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input bit keep_valid,
                       output bit accepted);
    accepted    = 1'b0;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = data;
    for (int k = 0; k < 20; k++) begin
      if (req_ready_o) begin
        @(posedge clk_i);
        accepted = 1'b1;
        @(negedge clk_i);
        break;
      end
      @(posedge clk_i);
      @(negedge clk_i);
    end
    if (!keep_valid || !accepted) req_valid_i = 1'b0;
  endtask

  // One full transaction with immediate response acceptance.
  task automatic run_txn(input logic we, input logic [31:0] addr,
                         input logic [31:0] data,
                         output logic [31:0] rdata, output logic err,
                         output int lat, output bit ok, output bit busy_ok);
    bit acc;
    issue(we, addr, data, 1'b0, acc);
    ok = acc; busy_ok = 1'b1; lat = 0; rdata = '0; err = 1'b0;
    rsp_ready_i = 1'b0;
    if (!acc) return;
    for (int k = 0; k < 50; k++) begin
      if (rsp_valid_o) break;
      if (req_ready_o) busy_ok = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      lat++;
    end
    if (!rsp_valid_o) begin
      ok = 1'b0;
      return;
    end
    if (req_ready_o) busy_ok = 1'b0;
    rdata = rsp_rdata_o;
    err   = rsp_err_o;
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    arst_ni = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0;
    req_addr_i = '0; req_wdata_i = '0; rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b, need 1 0 0 0",
               req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o);
    end
    arst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_rsp_ready_ignored: got ready=%b valid=%b, need 1 0", req_ready_o, rsp_valid_o);
    end
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat; bit ok, busy;
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat, ok, busy);
    n_checks++;
    if (!ok || lat != LAT || rd !== 32'h0 || er !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL store_0x10: got ok=%0d lat=%0d rdata=%h err=%b, need 1 %0d 0 0", ok, lat, rd, er, LAT);
    end
    n_checks++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL after_handshake: got ready=%b valid=%b rdata=%h, need 1 0 0",
               req_ready_o, rsp_valid_o, rsp_rdata_o);
    end
    run_txn(1'b0, 32'h10, 32'h0, rd, er, lat, ok, busy);
    n_checks++;
    if (!ok || lat != LAT || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL load_0x10: got ok=%0d lat=%0d rdata=%h err=%b, need 1 %0d deadbeef 0", ok, lat, rd, er, LAT);
    end
    n_checks++;
    if (!busy) begin
      n_fail++;
      $display("[TB] FAIL ready_low_while_busy: got req_ready_o=1 during transaction, need 0");
    end
  endtask

  task automatic test_hold_response();
    bit acc; logic [31:0] held;
    issue(1'b0, 32'h10, 32'h0, 1'b1, acc);
    req_addr_i = 32'h13; req_we_i = 1'b1;
    for (int k = 0; k < 20 && !rsp_valid_o; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    held = rsp_rdata_o;
    n_checks++;
    if (!acc || rsp_valid_o !== 1'b1 || held !== 32'hDEADBEEF) begin
      n_fail++;
      $display("[TB] FAIL hold_first: got acc=%0d valid=%b rdata=%h, need 1 1 deadbeef", acc, rsp_valid_o, held);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      n_checks++;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hDEADBEEF || req_ready_o !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL hold_cycle%0d: got valid=%b rdata=%h ready=%b, need 1 deadbeef 0",
                 k, rsp_valid_o, rsp_rdata_o, req_ready_o);
      end
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    n_checks++;
    if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0 || req_ready_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL hold_release: got valid=%b rdata=%h err=%b ready=%b, need 0 0 0 1",
               rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; bit ok, busy;
    run_txn(1'b1, 32'h0, 32'h0BADF00D, rd, er, lat, ok, busy);
    n_checks++;
    if (!ok || rd !== 32'h0 || er !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL store_word0: got ok=%0d rdata=%h err=%b, need 1 0 0", ok, rd, er);
    end
    run_txn(1'b0, 32'h13, 32'h0, rd, er, lat, ok, busy);
    n_checks++;
    if (!ok || rd !== 32'h0 || er !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL misaligned_load: got ok=%0d rdata=%h err=%b, need 1 0 1", ok, rd, er);
    end
    run_txn(1'b1, 32'h400, 32'h55AA55AA, rd, er, lat, ok, busy);
    n_checks++;
    if (!ok || rd !== 32'h0 || er !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL range_store: got ok=%0d rdata=%h err=%b, need 1 0 1", ok, rd, er);
    end
    run_txn(1'b1, 32'h2, 32'h77777777, rd, er, lat, ok, busy);
    n_checks++;
    if (!ok || rd !== 32'h0 || er !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL misaligned_store: got ok=%0d rdata=%h err=%b, need 1 0 1", ok, rd, er);
    end
    run_txn(1'b0, 32'h0, 32'h0, rd, er, lat, ok, busy);
    n_checks++;
    if (!ok || rd !== 32'h0BADF00D || er !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL word0_intact: got ok=%0d rdata=%h err=%b, need 1 0badf00d 0", ok, rd, er);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat; bit ok, busy, acc;
    run_txn(1'b1, 32'h20, 32'hAAAA5555, rd, er, lat, ok, busy);
    issue(1'b1, 32'h20, 32'h00001234, 1'b0, acc);
    arst_ni = 1'b0;
    #1;
    n_checks++;
    if (!acc || req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_outputs: got acc=%0d ready=%b valid=%b rdata=%h err=%b, need 1 1 0 0 0",
               acc, req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o);
    end
    repeat (3) @(negedge clk_i);
    arst_ni = 1'b1;
    @(negedge clk_i);
    run_txn(1'b0, 32'h20, 32'h0, rd, er, lat, ok, busy);
    n_checks++;
    if (!ok || rd !== 32'hAAAA5555 || er !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_no_write: got ok=%0d rdata=%h err=%b, need 1 aaaa5555 0", ok, rd, er);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic er; int lat; bit ok, busy, acc, seen, done;
    int nresp; int kind; logic [3:0] idx; logic we;
    logic [31:0] addr, data, exp_rd; logic exp_err;
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      run_txn(1'b1, 32'(i * 4), model[i], rd, er, lat, ok, busy);
    end
    nresp = 0;
    for (int t = 0; t < 5000; t++) begin
      idx  = 4'($urandom_range(0, 15));
      we   = 1'($urandom_range(0, 1));
      data = $urandom;
      kind = $urandom_range(0, 15);
      if (kind == 0)      addr = {26'h0, idx, 2'($urandom_range(1, 3))};
      else if (kind == 1) addr = ($urandom & 32'hFFFF_FFFC) | 32'h400;
      else                addr = {26'h0, idx, 2'b00};
      exp_err = (kind <= 1);
      exp_rd  = (exp_err || we) ? 32'h0 : model[idx];
      if (!exp_err && we) model[idx] = data;
      issue(we, addr, data, 1'b0, acc);
      seen = 1'b0; done = 1'b0; lat = 0;
      for (int s = 0; s < 200 && acc; s++) begin
        rsp_ready_i = 1'($urandom_range(0, 1));
        if (rsp_valid_o && !seen) begin
          seen = 1'b1;
          n_checks++;
          if (rsp_rdata_o !== exp_rd || rsp_err_o !== exp_err || lat != LAT) begin
            n_fail++;
            $display("[TB] FAIL random_%0d addr=%h we=%b: got rdata=%h err=%b lat=%0d, need %h %b %0d",
                     t, addr, we, rsp_rdata_o, rsp_err_o, lat, exp_rd, exp_err, LAT);
          end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        if (!seen) lat++;
        if (seen && rsp_ready_i) begin
          done = 1'b1;
          nresp++;
          break;
        end
      end
      rsp_ready_i = 1'b0;
      if (!done) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL random_%0d_timeout: got acc=%0d seen=%0d, need response handshake", t, acc, seen);
      end
      n_checks++;
      if (rsp_valid_o !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL random_%0d_single: got rsp_valid_o=%b after handshake, need 0", t, rsp_valid_o);
      end
    end
    n_checks++;
    if (nresp != 5000) begin
      n_fail++;
      $display("[TB] FAIL random_resp_count: got %0d, need 5000", nresp);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_hold_response();
    test_errors();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
